// File: rtl/nvdla_snap_pkg.sv
// nvdla_snap_pkg: shared state encoding and defaults for the NVDLA-to-SNAP interrupt bridge
package nvdla_snap_pkg;
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REQ      = 2'd1,
        WAIT_LOW = 2'd2,
        HOLDOFF  = 2'd3
    } state_t;
    localparam int INT_SRC_NVDLA       = 0;
    localparam int ACK_TIMEOUT_DEFAULT = 4096;
    localparam int HOLDOFF_DEFAULT     = 16;
endpackage

// File: rtl/nvdla_snap_intr_bridge.sv
// nvdla_snap_intr_bridge: NVDLA level interrupt to SNAP action interrupt req/ack handshake
module nvdla_snap_intr_bridge
    import nvdla_snap_pkg::*;
#(
    parameter int INT_BITS       = 3,
    parameter int CONTEXT_BITS   = 8,
    parameter int INT_SRC        = INT_SRC_NVDLA,
    parameter int ACK_TIMEOUT    = ACK_TIMEOUT_DEFAULT,
    parameter int HOLDOFF_CYCLES = HOLDOFF_DEFAULT,
    parameter int TMO_WIDTH      = 16,
    parameter int CNT_WIDTH      = 32
) (
    input  logic                    ap_clk,
    input  logic                    ap_rst_n,
    input  logic                    dla_intr,
    input  logic                    intr_enable,
    input  logic [CONTEXT_BITS-1:0] intr_ctx_i,
    output logic                    interrupt,
    output logic [INT_BITS-2:0]     interrupt_src,
    output logic [CONTEXT_BITS-1:0] interrupt_ctx,
    input  logic                    interrupt_ack,
    output logic                    intr_pending,
    output logic [CNT_WIDTH-1:0]    intr_count,
    output logic                    timeout_err,
    output logic                    spurious_ack_err,
    input  logic                    err_clr
);
    localparam logic [TMO_WIDTH-1:0] TMO_LAST  = TMO_WIDTH'(ACK_TIMEOUT == 0 ? 0 : ACK_TIMEOUT - 1);
    localparam logic [TMO_WIDTH-1:0] HOLD_LAST = TMO_WIDTH'(HOLDOFF_CYCLES - 1);

    state_t                  r_state, w_next;
    logic                    r_dla_q, r_int, r_pend, r_tmo_err, r_spur_err;
    logic [TMO_WIDTH-1:0]    r_cnt, w_cnt_next;
    logic [CONTEXT_BITS-1:0] r_ctx;
    logic [CNT_WIDTH-1:0]    r_count;
    logic                    w_int_next, w_start, w_acked, w_tmo_hit, w_spur;

    always_comb begin
        w_next     = r_state;
        w_cnt_next = r_cnt;
        w_int_next = r_int;
        w_start    = 1'b0;
        w_acked    = 1'b0;
        w_tmo_hit  = 1'b0;
        case (r_state)
            IDLE: if (intr_enable && r_dla_q) begin
                w_next     = REQ;
                w_int_next = 1'b1;
                w_cnt_next = '0;
                w_start    = 1'b1;
            end
            REQ: if (interrupt_ack) begin
                w_next     = WAIT_LOW;
                w_int_next = 1'b0;
                w_acked    = 1'b1;
            end else if (ACK_TIMEOUT != 0 && r_cnt == TMO_LAST) begin
                w_next     = HOLDOFF;
                w_int_next = 1'b0;
                w_cnt_next = '0;
                w_tmo_hit  = 1'b1;
            end else begin
                w_cnt_next = r_cnt + TMO_WIDTH'(1);
            end
            // holding here until the level clears keeps one NVDLA event from raising twice
            WAIT_LOW: if (!r_dla_q) begin
                w_next     = HOLDOFF;
                w_cnt_next = '0;
            end
            HOLDOFF: begin
                w_cnt_next = r_cnt + TMO_WIDTH'(1);
                w_next     = (r_cnt == HOLD_LAST) ? IDLE : HOLDOFF;
            end
            default: w_next = IDLE;
        endcase
    end

    assign w_spur = interrupt_ack && r_state != REQ;

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_state    <= IDLE;
            r_dla_q    <= 1'b0;
            r_int      <= 1'b0;
            r_pend     <= 1'b0;
            r_cnt      <= '0;
            r_ctx      <= '0;
            r_count    <= '0;
            r_tmo_err  <= 1'b0;
            r_spur_err <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_dla_q    <= dla_intr;
            r_int      <= w_int_next;
            r_pend     <= w_next != IDLE;
            r_cnt      <= w_cnt_next;
            r_ctx      <= w_start ? intr_ctx_i : r_ctx;
            r_count    <= w_acked ? r_count + CNT_WIDTH'(1) : r_count;
            r_tmo_err  <= w_tmo_hit || (r_tmo_err && !err_clr);
            r_spur_err <= w_spur || (r_spur_err && !err_clr);
        end
    end

    assign interrupt        = r_int;
    assign interrupt_src    = (INT_BITS-1)'(INT_SRC);
    assign interrupt_ctx    = r_ctx;
    assign intr_pending     = r_pend;
    assign intr_count       = r_count;
    assign timeout_err      = r_tmo_err;
    assign spurious_ack_err = r_spur_err;
endmodule
